// File: rtl/corescore_uart_pkg.sv
// Shared types and helpers for the corescore UART blocks.
package corescore_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   // Line bits per frame: start + data + optional parity + stop.
   function automatic int unsigned frame_bits(input int unsigned data_bits,
                                              input int unsigned parity,
                                              input int unsigned stop_bits);
      return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/corescore_sync_fifo.sv
// Single-clock FIFO with occupancy count; push ignored when full, pop ignored when empty.
module corescore_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic [$clog2(DEPTH):0]     o_level,
   output logic                       o_full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("corescore_sync_fifo: DEPTH must be a power of two >= 2");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    level;
   logic             do_push;
   logic             do_pop;

   assign o_full  = (level == LW'(DEPTH));
   assign do_push = i_push & ~o_full;
   assign do_pop  = i_pop & (level != '0);
   assign o_data  = mem[rd_ptr];
   assign o_level = level;

   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= i_data;
      end
   end

   // Pointers are exactly AW bits wide, so wrap-around is free for power-of-two depths.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/corescore_uart_tx.sv
// UART transmitter: FIFO-buffered, configurable data bits, parity and stop bits,
// gap-free back-to-back frames while words are queued.
module corescore_uart_tx
   import corescore_uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 16000000,
   parameter int unsigned BAUD_RATE   = 1000000,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY      = 0,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic [DATA_BITS-1:0]           i_data,
   input  logic                           i_valid,
   output logic                           o_ready,
   output logic                           o_uart_tx,
   output logic                           o_busy,
   output logic [$clog2(FIFO_DEPTH):0]    o_level
);

   localparam int unsigned DIV      = CLK_FREQ_HZ / BAUD_RATE;
   localparam int unsigned STOP_LEN = STOP_BITS * DIV;
   localparam int unsigned CW       = $clog2(STOP_LEN);
   localparam int unsigned LW       = $clog2(FIFO_DEPTH) + 1;

   localparam logic [CW-1:0] BIT_RELOAD  = CW'(DIV - 1);
   localparam logic [CW-1:0] STOP_RELOAD = CW'(STOP_LEN - 1);
   localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);

   if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY > 2 ||
       (STOP_BITS != 1 && STOP_BITS != 2) ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("corescore_uart_tx: illegal parameter combination");
   end

   tx_state_t            state;
   logic [CW-1:0]        cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 pop;
   logic                 fifo_full;
   logic [DATA_BITS-1:0] head;
   logic [LW-1:0]        level;

   // The FIFO gates pushes with its own full flag, which is exactly i_valid & o_ready.
   corescore_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (i_valid),
      .i_data  (i_data),
      .i_pop   (pop),
      .o_data  (head),
      .o_level (level),
      .o_full  (fifo_full)
   );

   assign o_ready = ~fifo_full;
   assign o_level = level;
   assign o_busy  = (state != ST_IDLE) || (level != '0);

   always_comb begin
      pop = 1'b0;
      if (level != '0) begin
         pop = (state == ST_IDLE) || ((state == ST_STOP) && (cnt == '0));
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         o_uart_tx <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               o_uart_tx <= 1'b1;
               if (pop) begin
                  shreg     <= head;
                  par_bit   <= (^head) ^ (PARITY == PAR_ODD);
                  cnt       <= BIT_RELOAD;
                  o_uart_tx <= 1'b0;
                  state     <= ST_START;
               end
            end
            ST_START: begin
               if (cnt == '0) begin
                  o_uart_tx <= shreg[0];
                  shreg     <= shreg >> 1;
                  bit_idx   <= '0;
                  cnt       <= BIT_RELOAD;
                  state     <= ST_DATA;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DATA: begin
               if (cnt == '0) begin
                  cnt <= BIT_RELOAD;
                  if (bit_idx == LAST_BIT) begin
                     if (PARITY != PAR_NONE) begin
                        o_uart_tx <= par_bit;
                        state     <= ST_PARITY;
                     end else begin
                        o_uart_tx <= 1'b1;
                        cnt       <= STOP_RELOAD;
                        state     <= ST_STOP;
                     end
                  end else begin
                     o_uart_tx <= shreg[0];
                     shreg     <= shreg >> 1;
                     bit_idx   <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_PARITY: begin
               if (cnt == '0) begin
                  o_uart_tx <= 1'b1;
                  cnt       <= STOP_RELOAD;
                  state     <= ST_STOP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_STOP: begin
               if (cnt == '0) begin
                  // A queued word starts its start bit straight after the stop bit(s).
                  if (pop) begin
                     shreg     <= head;
                     par_bit   <= (^head) ^ (PARITY == PAR_ODD);
                     cnt       <= BIT_RELOAD;
                     o_uart_tx <= 1'b0;
                     state     <= ST_START;
                  end else begin
                     o_uart_tx <= 1'b1;
                     state     <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               o_uart_tx <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_corescore_uart_tx.sv
// Bench for corescore_uart_tx: four parameterisations checked cycle by cycle against a
// frame-schedule model, plus hand-written vectors for frame shape, back-to-back and reset.
module tb_corescore_uart_tx;

   localparam int DIV   = 16;
   localparam int ND    = 4;
   localparam int DEPTH = 4;
   localparam int DB_C  [ND] = '{8, 8, 8, 7};
   localparam int PAR_C [ND] = '{0, 1, 2, 2};
   localparam int SB_C  [ND] = '{1, 1, 1, 2};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vld [ND];
   logic [7:0] din [ND];
   logic       tx  [ND];
   logic       busy[ND];
   logic       rdy [ND];
   logic [2:0] lvl [ND];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   corescore_uart_tx #(.CLK_FREQ_HZ(16000000), .BAUD_RATE(1000000), .DATA_BITS(8),
                       .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(din[0]), .i_valid(vld[0]),
      .o_ready(rdy[0]), .o_uart_tx(tx[0]), .o_busy(busy[0]), .o_level(lvl[0]));

   corescore_uart_tx #(.CLK_FREQ_HZ(16000000), .BAUD_RATE(1000000), .DATA_BITS(8),
                       .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(din[1]), .i_valid(vld[1]),
      .o_ready(rdy[1]), .o_uart_tx(tx[1]), .o_busy(busy[1]), .o_level(lvl[1]));

   corescore_uart_tx #(.CLK_FREQ_HZ(16000000), .BAUD_RATE(1000000), .DATA_BITS(8),
                       .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(din[2]), .i_valid(vld[2]),
      .o_ready(rdy[2]), .o_uart_tx(tx[2]), .o_busy(busy[2]), .o_level(lvl[2]));

   corescore_uart_tx #(.CLK_FREQ_HZ(16000000), .BAUD_RATE(1000000), .DATA_BITS(7),
                       .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(din[3][6:0]), .i_valid(vld[3]),
      .o_ready(rdy[3]), .o_uart_tx(tx[3]), .o_busy(busy[3]), .o_level(lvl[3]));

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: each accepted word is scheduled as a frame starting at edge s.
   typedef struct {
      int         d;
      int         s;
      logic [7:0] data;
   } fr_t;

   fr_t frames[$];
   int  m_level[ND];
   int  m_tend [ND];
   bit  m_acc  [ND];
   int  edge_n = 0;

   function automatic int fl(input int d);
      return 1 + DB_C[d] + ((PAR_C[d] != 0) ? 1 : 0) + SB_C[d];
   endfunction

   function automatic logic exp_bit(input int d, input logic [7:0] data, input int j);
      logic p;
      p = 1'b0;
      for (int i = 0; i < DB_C[d]; i++) p ^= data[i];
      if (PAR_C[d] == 2) p = ~p;
      if (j == 0) return 1'b0;
      if (j <= DB_C[d]) return data[j-1];
      if (PAR_C[d] != 0 && j == DB_C[d] + 1) return p;
      return 1'b1;
   endfunction

   function automatic void expect_out(input int d, output logic etx, output logic ebusy);
      etx   = 1'b1;
      ebusy = (m_level[d] != 0);
      foreach (frames[i]) begin
         if (frames[i].d == d && edge_n >= frames[i].s && edge_n < frames[i].s + fl(d) * DIV) begin
            etx   = exp_bit(d, frames[i].data, (edge_n - frames[i].s) / DIV);
            ebusy = 1'b1;
         end
      end
   endfunction

   function automatic bit model_idle();
      bit r;
      r = (frames.size() == 0);
      for (int d = 0; d < ND; d++) if (m_level[d] != 0) r = 1'b0;
      return r;
   endfunction

   task automatic model_clear();
      frames.delete();
      for (int d = 0; d < ND; d++) begin
         m_level[d] = 0;
         m_tend[d]  = 0;
         m_acc[d]   = 1'b0;
      end
   endtask

   always @(posedge clk) begin
      edge_n++;
      for (int d = 0; d < ND; d++) begin
         int  pops;
         fr_t f;
         pops     = 0;
         m_acc[d] = 1'b0;
         if (rst_n) begin
            foreach (frames[i]) if (frames[i].d == d && frames[i].s == edge_n) pops++;
            m_acc[d] = vld[d] && (m_level[d] != DEPTH);
            if (m_acc[d]) begin
               f.d    = d;
               f.data = din[d];
               f.s    = (edge_n + 1 > m_tend[d]) ? edge_n + 1 : m_tend[d];
               m_tend[d] = f.s + fl(d) * DIV;
               frames.push_back(f);
            end
            m_level[d] = m_level[d] + (m_acc[d] ? 1 : 0) - pops;
         end
      end
      for (int i = frames.size() - 1; i >= 0; i--)
         if (frames[i].s + fl(frames[i].d) * DIV < edge_n) frames.delete(i);
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < ND; d++) begin
            logic etx, ebusy;
            expect_out(d, etx, ebusy);
            chk($sformatf("tx%0d", d),    int'(tx[d]),   int'(etx));
            chk($sformatf("busy%0d", d),  int'(busy[d]), int'(ebusy));
            chk($sformatf("level%0d", d), int'(lvl[d]),  m_level[d]);
            chk($sformatf("ready%0d", d), int'(rdy[d]),  (m_level[d] != DEPTH) ? 1 : 0);
         end
      end
   end

   task automatic wait_idle();
      int k;
      k = 0;
      while (!model_idle() && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 5000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got busy after %0d cycles, expected idle", k);
      end
      @(negedge clk);
   endtask

   typedef struct {
      int          d;
      logic [7:0]  data;
      int          nbits;
      logic [11:0] bits;
      int          len;
   } vec_t;

   vec_t vt [4];
   logic [7:0] bseq [6];

   initial begin
      int bc, idx, lowcnt;
      bit done;

      // Line bits listed from bit 0 (start) upward: {stop(s), parity, data, start}.
      vt[0] = '{d:0, data:8'h55, nbits:10, bits:{2'b00, 1'b1, 8'h55, 1'b0}, len:160};
      vt[1] = '{d:1, data:8'h07, nbits:11, bits:{1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, len:176};
      vt[2] = '{d:2, data:8'h07, nbits:11, bits:{1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, len:176};
      vt[3] = '{d:3, data:8'h41, nbits:11, bits:{1'b1, 1'b1, 1'b1, 7'h41, 1'b0}, len:176};
      bseq  = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h18};

      for (int d = 0; d < ND; d++) begin
         vld[d] = 1'b0;
         din[d] = '0;
      end
      model_clear();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("rst_tx%0d", d),    int'(tx[d]),   1);
         chk($sformatf("rst_busy%0d", d),  int'(busy[d]), 0);
         chk($sformatf("rst_level%0d", d), int'(lvl[d]),  0);
         chk($sformatf("rst_ready%0d", d), int'(rdy[d]),  1);
      end
      rst_n = 1'b1;

      // Frame shape, parity and length per configuration.
      for (int i = 0; i < 4; i++) begin
         int d;
         d = vt[i].d;
         wait_idle();
         vld[d] = 1'b1;
         din[d] = vt[i].data;
         @(negedge clk);
         vld[d] = 1'b0;
         chk($sformatf("v%0d_pre_start", i), int'(tx[d]),  1);
         chk($sformatf("v%0d_level1", i),    int'(lvl[d]), 1);
         @(negedge clk);
         chk($sformatf("v%0d_start_edge", i), int'(tx[d]), 0);
         bc   = 0;
         done = 1'b0;
         for (int k = 0; k < 400 && !done; k++) begin
            if (k % DIV == DIV / 2 && k / DIV < vt[i].nbits)
               chk($sformatf("v%0d_bit%0d", i, k / DIV), int'(tx[d]), int'(vt[i].bits[k / DIV]));
            if (busy[d]) bc++;
            else done = 1'b1;
            if (!done) @(negedge clk);
         end
         chk($sformatf("v%0d_frame_len", i), bc, vt[i].len);
      end

      // Back-to-back with i_valid held through six words.
      wait_idle();
      idx    = 0;
      vld[0] = 1'b1;
      din[0] = bseq[0];
      bc     = 0;
      done   = 1'b0;
      for (int k = 0; k < 2000 && !done; k++) begin
         @(negedge clk);
         if (m_acc[0]) begin
            idx++;
            if (idx < 6) din[0] = bseq[idx];
            else vld[0] = 1'b0;
         end
         if (k == 4) begin
            chk("b2b_level_full", int'(lvl[0]), 4);
            chk("b2b_ready_low",  int'(rdy[0]), 0);
         end
         if (k == 100) chk("b2b_ready_mid_frame", int'(rdy[0]), 0);
         if (k == 161) chk("b2b_ready_after_frame", int'(rdy[0]), 1);
         if (busy[0]) bc++;
         else done = 1'b1;
      end
      chk("b2b_busy_len", bc, 961);

      // Stalled push: data changes every cycle while the FIFO is full.
      wait_idle();
      vld[0] = 1'b1;
      for (int k = 0; k < 600; k++) begin
         din[0] = 8'($urandom);
         @(negedge clk);
      end
      vld[0] = 1'b0;

      // Random traffic on every configuration.
      wait_idle();
      for (int k = 0; k < 3000; k++) begin
         for (int d = 0; d < ND; d++) begin
            vld[d] = ($urandom_range(0, 3) == 0);
            din[d] = 8'($urandom);
         end
         @(negedge clk);
      end
      for (int d = 0; d < ND; d++) vld[d] = 1'b0;

      // Reset 40 cycles into a frame with two more words queued.
      wait_idle();
      vld[0] = 1'b1;
      din[0] = 8'hC1;
      @(negedge clk);
      din[0] = 8'h5A;
      @(negedge clk);
      din[0] = 8'h96;
      @(negedge clk);
      vld[0] = 1'b0;
      repeat (39) @(negedge clk);
      chk("mid_frame_line_low", int'(tx[0]), 0);
      chk("mid_frame_level",    int'(lvl[0]), 2);
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      chk("arst_tx",    int'(tx[0]),   1);
      chk("arst_level", int'(lvl[0]),  0);
      chk("arst_busy",  int'(busy[0]), 0);
      chk("arst_ready", int'(rdy[0]),  1);
      repeat (2) @(negedge clk);
      chk("rst_hold_tx", int'(tx[0]), 1);
      rst_n  = 1'b1;
      lowcnt = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (!tx[0]) lowcnt++;
      end
      chk("post_rst_low_cycles", lowcnt, 0);
      chk("post_rst_busy", int'(busy[0]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      n_bad++;
      $display("FAIL watchdog: got no completion by t=%0t, expected end of test", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1);
   end

endmodule
